// File: rtl/race_pkg.sv
// Shared encodings for the race game: screen codes seen by the player and renderer
// blocks, controller FSM states, and small constant helpers for sizing.
package race_pkg;

    localparam logic [1:0] SCREEN_MENU      = 2'b00;
    localparam logic [1:0] SCREEN_RACE      = 2'b01;
    localparam logic [1:0] SCREEN_WINNER    = 2'b10;
    localparam logic [1:0] SCREEN_COUNTDOWN = 2'b11;

    typedef enum logic [2:0] {
        ST_MENU,
        ST_COUNTDOWN,
        ST_RACE,
        ST_WINNER,
        ST_RESTART
    } state_t;

    function automatic int at_least1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int winner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] screen_of(input state_t s);
        case (s)
            ST_COUNTDOWN: return SCREEN_COUNTDOWN;
            ST_RACE:      return SCREEN_RACE;
            ST_WINNER:    return SCREEN_WINNER;
            default:      return SCREEN_MENU;
        endcase
    endfunction

endpackage

// File: rtl/race_controller_if.sv
// Bundle between the player lanes, the race controller and the LED renderer.
// master = controller side, slave = player/renderer side.
interface race_controller_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int MAX_POS     = 16
) ();
    localparam int PW = $clog2(MAX_POS);
    localparam int WW = race_pkg::winner_w(NUM_PLAYERS);

    logic [NUM_PLAYERS-1:0]    ready_to_play;
    logic [NUM_PLAYERS*PW-1:0] pos_flat;
    logic [1:0]                current_screen;
    logic [1:0]                countdown;
    logic [WW-1:0]             winner;
    logic                      winner_valid;
    logic                      players_reset;

    modport master (
        input  ready_to_play, pos_flat,
        output current_screen, countdown, winner, winner_valid, players_reset
    );

    modport slave (
        output ready_to_play, pos_flat,
        input  current_screen, countdown, winner, winner_valid, players_reset
    );
endinterface

// File: rtl/race_controller_tick_timer.sv
// tick_timer: loadable down-counter; o_expire is high during the cycle the count is 1,
// so a load of N expires N cycles later. Stops at 0 until reloaded.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_expire
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)               r_cnt <= '0;
        else if (i_load)         r_cnt <= i_val;
        else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
    end

    assign o_expire = (r_cnt == W'(1));
endmodule

// File: rtl/race_controller.sv
// race_controller: game-flow FSM (menu, countdown, race, winner, restart).
// Optional partial-start timeout enabled by defining RACE_PARTIAL_START_EN.
module race_controller
    import race_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int MAX_POS     = 16,
    parameter int COUNT_TICKS = 50_000_000,
    parameter int WIN_HOLD    = 150_000_000,
    parameter int START_WAIT  = 250_000_000
) (
    input  logic              clk,
    input  logic              reset,
    race_controller_if.master bus
);
    localparam int PW = $clog2(MAX_POS);
    localparam int WW = winner_w(NUM_PLAYERS);
    localparam int TW = $clog2(max3(at_least1(COUNT_TICKS), at_least1(WIN_HOLD),
                                    at_least1(START_WAIT)) + 1);
    localparam logic [TW-1:0] CT_LD = TW'(at_least1(COUNT_TICKS));
    localparam logic [TW-1:0] WH_LD = TW'(at_least1(WIN_HOLD));

    state_t                 r_state, w_state_nxt;
    logic [1:0]             r_screen, r_countdown, w_cd_nxt;
    logic [WW-1:0]          r_winner, w_win_nxt, w_first;
    logic                   r_valid, r_preset;
    logic                   w_t_load, w_t_exp;
    logic [TW-1:0]          w_t_val;
    logic                   w_start, w_lost;
    logic [NUM_PLAYERS-1:0] w_race_mask, w_hit;

`ifdef RACE_PARTIAL_START_EN
    localparam logic [TW-1:0] SW_LD = TW'(at_least1(START_WAIT));
    logic [NUM_PLAYERS-1:0] r_ready_prev, r_frozen, w_rise;
    logic                   w_sw_load, w_sw_exp;

    assign w_rise    = bus.ready_to_play & ~r_ready_prev;
    assign w_sw_load = (r_state == ST_MENU) && (|w_rise);

    tick_timer #(.W(TW)) u_start_tmr (
        .clk(clk), .reset(reset), .i_load(w_sw_load), .i_val(SW_LD), .o_expire(w_sw_exp)
    );

    // Lanes present at countdown entry are the only ones allowed to race.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready_prev <= '0;
            r_frozen     <= '0;
        end else begin
            r_ready_prev <= bus.ready_to_play;
            if (r_state == ST_MENU && w_state_nxt == ST_COUNTDOWN)
                r_frozen <= bus.ready_to_play;
        end
    end

    assign w_start     = (&bus.ready_to_play) ||
                         ((|bus.ready_to_play) && w_sw_exp && !(|w_rise));
    assign w_lost      = (bus.ready_to_play & r_frozen) != r_frozen;
    assign w_race_mask = bus.ready_to_play & r_frozen;
`else
    assign w_start     = &bus.ready_to_play;
    assign w_lost      = ~(&bus.ready_to_play);
    assign w_race_mask = bus.ready_to_play;
`endif

    always_comb begin
        w_hit   = '0;
        w_first = '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            w_hit[i] = w_race_mask[i] && (bus.pos_flat[i*PW +: PW] == PW'(MAX_POS - 1));
        // Scan downward so the lowest finishing index is the one left standing.
        for (int i = NUM_PLAYERS - 1; i >= 0; i--)
            if (w_hit[i]) w_first = WW'(i);
    end

    // Countdown steps and winner hold never overlap, so they share one timer.
    tick_timer #(.W(TW)) u_step_tmr (
        .clk(clk), .reset(reset), .i_load(w_t_load), .i_val(w_t_val), .o_expire(w_t_exp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_countdown;
        w_win_nxt   = r_winner;
        w_t_load    = 1'b0;
        w_t_val     = CT_LD;
        case (r_state)
            ST_MENU: if (w_start) begin
                w_state_nxt = ST_COUNTDOWN;
                w_cd_nxt    = 2'd3;
                w_t_load    = 1'b1;
            end
            ST_COUNTDOWN: begin
                if (w_lost) begin
                    w_state_nxt = ST_MENU;
                    w_cd_nxt    = 2'd0;
                end else if (w_t_exp) begin
                    if (r_countdown == 2'd1) begin
                        w_state_nxt = ST_RACE;
                        w_cd_nxt    = 2'd0;
                    end else begin
                        w_cd_nxt = r_countdown - 2'd1;
                        w_t_load = 1'b1;
                    end
                end
            end
            ST_RACE: if (|w_hit) begin
                w_state_nxt = ST_WINNER;
                w_win_nxt   = w_first;
                w_t_load    = 1'b1;
                w_t_val     = WH_LD;
            end
            ST_WINNER: if (w_t_exp) begin
                w_state_nxt = ST_RESTART;
                w_win_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_MENU;
                w_win_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_MENU;
            r_screen    <= SCREEN_MENU;
            r_countdown <= 2'd0;
            r_winner    <= '0;
            r_valid     <= 1'b0;
            r_preset    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_screen    <= screen_of(w_state_nxt);
            r_countdown <= w_cd_nxt;
            r_winner    <= w_win_nxt;
            r_valid     <= (w_state_nxt == ST_WINNER);
            r_preset    <= (w_state_nxt == ST_RESTART);
        end
    end

    assign bus.current_screen = r_screen;
    assign bus.countdown      = r_countdown;
    assign bus.winner         = r_winner;
    assign bus.winner_valid   = r_valid;
    assign bus.players_reset  = r_preset;
endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Game-flow sequencer directly downstream of the per-player button blocks.
- Consumes each player's ready_to_play and cur_pos.
- Produces the shared current_screen those blocks obey, detects the winner, and issues the player-reset pulse that returns the game to the menu.
- Sits between the player inputs and the LED renderer, which reads current_screen, countdown and winner.

Parameters:
- NUM_PLAYERS, 4, number of player lanes (2..8).
- MAX_POS, 16, LED positions per lane; finish is MAX_POS-1.
- COUNT_TICKS, 50_000_000, clk cycles per countdown step.
- WIN_HOLD, 150_000_000, clk cycles the winner screen is held.
- START_WAIT, 250_000_000, clk cycles of the partial-start timeout (feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ready_to_play  in  NUM_PLAYERS  per-player ready flags.
- pos_flat  in  NUM_PLAYERS*PW  concatenated cur_pos values; PW=$clog2(MAX_POS); player i at bits [i*PW +: PW].
- current_screen  out  2  00 MENU, 01 RACE, 10 WINNER, 11 COUNTDOWN.
- countdown  out  2  remaining count 3..1 during COUNTDOWN, else 0.
- winner  out  max(1,$clog2(NUM_PLAYERS))  index of the winning player.
- winner_valid  out  1  high only while the screen is WINNER.
- players_reset  out  1  drives the reset input of every player block.

Behaviour:
- All outputs are registered.
- Reset values:
  - current_screen=00; countdown=0; winner=0; winner_valid=0.
  - players_reset=1 while reset is high; it falls in the first cycle after reset deasserts.
  - FSM enters MENU.
- FSM states: MENU, COUNTDOWN, RACE, WINNER, RESTART.
- MENU (screen 00):
  - Moves to COUNTDOWN when ready_to_play is all ones.
  - The transition cycle loads countdown=3 and the step timer with COUNT_TICKS.
- COUNTDOWN (screen 11):
  - Players ignore button presses on this screen.
  - Each COUNT_TICKS cycles, countdown decrements.
  - When the step at countdown=1 expires, the FSM goes to RACE and countdown=0.
  - Total dwell is 3*COUNT_TICKS cycles.
- RACE (screen 01):
  - Each cycle, compares every ready player's position with MAX_POS-1.
  - Positions of non-ready players are ignored.
  - On any match, the next cycle shows: screen 10, winner_valid=1, winner latched, hold timer loaded with WIN_HOLD.
  - Latency from the finishing position to WINNER is one cycle.
- Simultaneous finishers in the same cycle: the lowest index wins.
- WINNER (screen 10):
  - winner and winner_valid hold for WIN_HOLD cycles.
  - Position inputs are ignored in this state.
  - Then goes to RESTART.
- RESTART:
  - Lasts one cycle: players_reset=1, winner_valid=0, winner cleared to 0, screen 00.
  - Then MENU.
- players_reset is high only in reset and RESTART. It is never high in any other state.
- Ready drop mid-countdown:
  - If ready_to_play stops being all ones (all ones is required only without the feature), the FSM returns to MENU with countdown=0.
  - This cannot happen in normal play, but the behaviour is required.
- Timer rules:
  - Timers count down and expire at 1.
  - Timer width is $clog2(max(COUNT_TICKS,WIN_HOLD,START_WAIT)+1).
  - A parameter value of 0 is treated as 1.
- Reset mid-operation:
  - Reset in any state forces the full reset values above on the next edge.
  - The timers and the latched winner are cleared.

Optional Feature:
- Macro: RACE_PARTIAL_START_EN.
- Defined:
  - MENU also leaves to COUNTDOWN when at least one player is ready and no new ready bit has risen for START_WAIT cycles.
  - The timer reloads on each new ready bit.
  - All-ready still starts immediately.
  - The set of ready players is frozen at COUNTDOWN entry; only frozen players can win.
- Undefined:
  - Only the all-ready start exists.
  - START_WAIT is unused.

Decomposition:
- race_pkg holds:
  - Screen encodings SCREEN_MENU=2'b00, SCREEN_RACE=2'b01, SCREEN_WINNER=2'b10, SCREEN_COUNTDOWN=2'b11. These are shared with the player and renderer blocks.
  - The FSM state encodings.
- One sub-module, tick_timer: a loadable down-counter with an expire strobe, parameterised by width.
  - Instantiated once for the countdown/win hold, since those states never overlap.
  - Instantiated once for the partial-start timeout, only when the feature is enabled.

Test Plan (NUM_PLAYERS=2, MAX_POS=4, COUNT_TICKS=3, WIN_HOLD=5, START_WAIT=6):
- Reset → next cycle screen=00, countdown=0, winner_valid=0, players_reset=1; players_reset=0 one cycle after reset falls.
- Ready=2'b11 → screen=11 with countdown 3,2,1 for 3 cycles each, then screen=01, countdown=0.
- In RACE, player1 pos goes to 3 → next cycle screen=10, winner=1, winner_valid=1 for 5 cycles; then one cycle of players_reset=1 with screen=00.
- Both positions reach 3 in the same cycle → winner=0.
- Ready=2'b01 without the feature → stays in MENU indefinitely. With RACE_PARTIAL_START_EN → COUNTDOWN entered 6 cycles after bit 0 rose.
- Reset asserted mid-COUNTDOWN and mid-WINNER → all outputs return to reset values next cycle.
